// File: rtl/sm83_dbg_uart.sv
// 8N1 UART link layer for the SM83 debug interface: RX deserialiser into a
// toggle-handshake receive port, TX serialiser from a toggle-handshake transmit port.
module sm83_dbg_uart #(
  parameter int BAUD_DIV    = 217,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       nreset,
  input  logic       uart_rx,
  output logic       uart_tx,
  output logic [7:0] data_rx,
  output logic       data_rx_valid,
  output logic       data_rx_seq,
  input  logic       data_rx_ack,
  input  logic [7:0] data_tx,
  input  logic       data_tx_seq,
  output logic       data_tx_ack,
  output logic       rx_overrun
);

  // Counters load N-1 and expire at zero, so a load of BIT_LAST spans BAUD_DIV cycles.
  localparam logic [15:0] BIT_LAST  = 16'(BAUD_DIV - 1);
  localparam logic [15:0] HALF_LAST = 16'(BAUD_DIV / 2 - 1);

  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_HIGH} rx_state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

  logic [SYNC_STAGES-1:0] sync;
  logic                   line;

  always_ff @(posedge clk) begin
    if (!nreset) sync <= '1;
    else         sync <= {sync[SYNC_STAGES-2:0], uart_rx};
  end

  assign line = sync[SYNC_STAGES-1];

  rx_state_t   rx_state;
  logic [15:0] rx_cnt;
  logic [2:0]  rx_idx;
  logic [7:0]  rx_shift;

  always_ff @(posedge clk) begin
    if (!nreset) begin
      rx_state      <= RX_IDLE;
      rx_cnt        <= '0;
      rx_idx        <= '0;
      rx_shift      <= '0;
      data_rx       <= '0;
      data_rx_valid <= 1'b0;
      data_rx_seq   <= 1'b0;
      rx_overrun    <= 1'b0;
    end else begin
      rx_overrun <= 1'b0;
      if (rx_cnt != '0) rx_cnt <= rx_cnt - 1'b1;
      case (rx_state)
        RX_IDLE: begin
          if (!line) begin
            rx_state <= RX_START;
            rx_cnt   <= HALF_LAST;
          end
        end
        RX_START: begin
          if (rx_cnt == '0) begin
            if (line) begin
              rx_state <= RX_IDLE;
            end else begin
              rx_state <= RX_DATA;
              rx_cnt   <= BIT_LAST;
              rx_idx   <= '0;
            end
          end
        end
        RX_DATA: begin
          if (rx_cnt == '0) begin
            rx_shift <= {line, rx_shift[7:1]};
            rx_cnt   <= BIT_LAST;
            rx_idx   <= rx_idx + 1'b1;
            if (rx_idx == 3'd7) rx_state <= RX_STOP;
          end
        end
        RX_STOP: begin
          if (rx_cnt == '0) begin
            // Unconsumed previous byte wins; the new one is dropped and flagged.
            if (data_rx_seq != data_rx_ack) begin
              rx_overrun <= 1'b1;
            end else begin
              data_rx       <= rx_shift;
              data_rx_valid <= line;
              data_rx_seq   <= ~data_rx_seq;
            end
            rx_state <= line ? RX_IDLE : RX_WAIT_HIGH;
          end
        end
        RX_WAIT_HIGH: begin
          if (line) rx_state <= RX_IDLE;
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  tx_state_t   tx_state;
  logic [15:0] tx_cnt;
  logic [2:0]  tx_idx;
  logic [7:0]  tx_shift;

  always_ff @(posedge clk) begin
    if (!nreset) begin
      tx_state    <= TX_IDLE;
      tx_cnt      <= '0;
      tx_idx      <= '0;
      tx_shift    <= '0;
      uart_tx     <= 1'b1;
      data_tx_ack <= 1'b0;
    end else begin
      if (tx_cnt != '0) tx_cnt <= tx_cnt - 1'b1;
      case (tx_state)
        TX_IDLE: begin
          if (data_tx_seq != data_tx_ack) begin
            tx_shift <= data_tx;
            uart_tx  <= 1'b0;
            tx_cnt   <= BIT_LAST;
            tx_state <= TX_START;
          end
        end
        TX_START: begin
          if (tx_cnt == '0) begin
            uart_tx  <= tx_shift[0];
            tx_shift <= {1'b0, tx_shift[7:1]};
            tx_cnt   <= BIT_LAST;
            tx_idx   <= '0;
            tx_state <= TX_DATA;
          end
        end
        TX_DATA: begin
          if (tx_cnt == '0) begin
            tx_cnt <= BIT_LAST;
            tx_idx <= tx_idx + 1'b1;
            if (tx_idx == 3'd7) begin
              uart_tx  <= 1'b1;
              tx_state <= TX_STOP;
            end else begin
              uart_tx  <= tx_shift[0];
              tx_shift <= {1'b0, tx_shift[7:1]};
            end
          end
        end
        TX_STOP: begin
          if (tx_cnt == '0) begin
            data_tx_ack <= data_tx_seq;
            tx_state    <= TX_IDLE;
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

endmodule

// File: doc/sm83_dbg_uart.md
Name: sm83_dbg_uart

Overview:
Serial link layer for the SM83 debug interface. It deserialises 8N1 UART frames from the host into the debug interface's toggle-handshake receive port (data_rx/data_rx_seq/data_rx_ack). It also serialises bytes offered on the debug interface's transmit handshake (data_tx/data_tx_seq/data_tx_ack) back to the host. It sits between the board UART pins and the debug interface, in the same clock domain as the CPU core.

Parameters:
BAUD_DIV, 217, clock cycles per bit period (217 gives 115200 baud from 25 MHz); legal range 4..65535
SYNC_STAGES, 2, flip-flop stages on the rx pin synchroniser; legal range 2..3

Ports:
clk  input  1  system clock, all logic on rising edge
nreset  input  1  synchronous active-low reset, sampled on rising clk
uart_rx  input  1  asynchronous serial input from host, idles high
uart_tx  output  1  serial output to host, idles high
data_rx  output  8  last received byte
data_rx_valid  output  1  1 = byte framed correctly; 0 = framing error
data_rx_seq  output  1  toggles once per delivered byte
data_rx_ack  input  1  consumer sets equal to data_rx_seq when the byte is consumed
data_tx  input  8  byte to send; must be stable while data_tx_seq != data_tx_ack
data_tx_seq  input  1  producer toggles to request transmission of data_tx
data_tx_ack  output  1  set equal to data_tx_seq when the byte's stop bit completes
rx_overrun  output  1  one-cycle pulse when a received byte is dropped

Behaviour:
- Reset (nreset=0 at a clock edge):
  - uart_tx=1, data_rx=0, data_rx_valid=0, data_rx_seq=0, data_tx_ack=0, rx_overrun=0.
  - Both FSMs go to IDLE, counters clear, and the synchroniser presets to 1.
  - Reset mid-frame aborts the frame with no delivery. A partially sent TX frame is cut, and uart_tx returns high in the reset cycle.
- The RX path samples uart_rx only after the SYNC_STAGES synchroniser. All references to "line" below mean the synchronised value.
- RX FSM states: IDLE, START, DATA, STOP, WAIT_HIGH.
  - IDLE: the line is sampled 0 -> go to START, bit counter = BAUD_DIV/2 (integer divide).
  - START: at counter expiry, resample the line.
    - Line 1 -> false start, go to IDLE.
    - Line 0 -> go to DATA, reload BAUD_DIV, bit index 0.
  - DATA: at each expiry, shift the sampled bit in LSB-first. After the 8th bit go to STOP with BAUD_DIV reloaded.
  - STOP: at expiry, sample the stop bit and deliver the byte in the same edge, subject to the overrun rule below.
    - Delivery registers: data_rx = shifted byte, data_rx_valid = stop bit, data_rx_seq toggled.
    - Stop bit 1 -> go to IDLE.
    - Stop bit 0 (framing error or break) -> go to WAIT_HIGH.
  - WAIT_HIGH: stay until the line reads 1, then go to IDLE. No new start bit is detected while the line stays low.
- Delivery latency: data_rx_seq toggles on the clock edge at the mid-stop-bit sample.
- Overrun: if data_rx_seq != data_rx_ack at delivery time:
  - the new byte is discarded;
  - data_rx, data_rx_valid and data_rx_seq are unchanged;
  - rx_overrun = 1 for exactly one cycle.
  - The FSM still proceeds to IDLE or WAIT_HIGH as normal.
- data_rx and data_rx_valid change only on a delivery edge and are held stable otherwise.
- TX FSM states: IDLE, START, DATA, STOP.
  - IDLE: data_tx_seq != data_tx_ack -> latch data_tx into the shift register, go to START.
    - uart_tx=0 from the next cycle, for BAUD_DIV cycles.
  - DATA: 8 bits LSB-first, BAUD_DIV cycles each.
  - STOP: uart_tx=1 for BAUD_DIV cycles. In the final cycle of STOP, set data_tx_ack = data_tx_seq and go to IDLE.
- The TX frame is exactly 10*BAUD_DIV cycles. Back-to-back frames have no extra idle bit: if the request is already pending, the next start bit begins the cycle after ack.
- data_tx is latched once; changes after the latch do not affect the frame in flight.
- A second toggle of data_tx_seq during a frame is ignored until ack. The handshake compares only equality, so a double toggle reads as no request.
- RX and TX are fully independent and may run simultaneously.
- uart_tx is driven directly from a register (glitch-free).

Test Plan:
1. BAUD_DIV=8. Host sends 0xA5 (8N1). Required: data_rx=0xA5, data_rx_valid=1, data_rx_seq 0->1 at 9.5 bit times ±1 clk (plus synchroniser delay) after the start edge; rx_overrun=0.
2. Stop bit held low on 0x3C, then line high. Required: data_rx=0x3C, data_rx_valid=0. The next frame 0x81 is received correctly only after the line returns high.
3. Two frames 0x11 and 0x22 with data_rx_ack never toggled. Required: data_rx stays 0x11, data_rx_seq toggles once, rx_overrun pulses exactly 1 cycle at the second stop sample.
4. data_tx=0x5A, data_tx_seq 0->1. Required: uart_tx shows 0, then 0,1,0,1,1,0,1,0, then 1, each bit 8 clks; data_tx_ack=1 exactly 80 clks after the start bit began. A pending second byte 0xFF starts its start bit the following cycle.
5. A 3-clk low glitch on uart_rx while idle (BAUD_DIV=8). Required: no delivery, data_rx_seq unchanged, and the RX FSM back in IDLE.
6. nreset=0 asserted mid-TX and mid-RX frame. Required: uart_tx=1 in the reset cycle, all outputs at reset values, no spurious delivery after release, and a clean 0x42 round trip afterwards.
